sin_lut_10_sync: RTL
====================

Name: sin_lut_10_sync

Overview:
- Receive-side counterpart of the 10-sample sine LUT generator.
- Consumes a stream of signed 16-bit samples and phase-locks to the fixed 10-entry sine sequence: 0, 21063, 32270, 28378, 11207, -11207, -28378, -32270, -21063, 0, then repeat.
- Reports lock status, current phase index, a sample-error count and a loss-of-lock pulse.
- Sits at the far end of a sample link and provides a self-check for the generator and the path.

Parameters:
- TOL, 0, max allowed |sample - expected| for a match. Legal range 0..1945, which keeps nonzero entries uniquely distinguishable.
- LOCK_CNT, 4, consecutive matches (including the first hunt match) needed to declare lock. Range 1..15.
- MISS_MAX, 3, consecutive mismatches while locked that cause loss of lock. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample strobe; one sample per cycle when high.
- in  in  16  signed sample.
- locked  out  1  high while in LOCKED.
- phase  out  4  table index (0..9) of the last accepted sample.
- err_cnt  out  16  mismatches seen in LOCKED; saturates at 65535.
- lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On rst:
  - state = HUNT; locked = 0, phase = 0, err_cnt = 0, lost = 0.
  - exp_idx = 0, match_cnt = 0, miss_cnt = 0.
  - Reset mid-operation takes effect immediately (async) and discards all history.
- All outputs are registered and update on the clk edge that samples in_valid = 1 (latency 1 cycle).
- When in_valid = 0: no state, counter or output change, except lost, which is forced low.
- Match rule: |in - tbl[i]| <= TOL. Compute with a 17-bit signed difference, then take the magnitude; no overflow is possible.
- HUNT:
  - Compare in against entries 1..8 only. Zero entries (0 and 9) are ambiguous and never start acquisition.
  - Exactly one match at k: phase = k, exp_idx = (k+1) mod 10, match_cnt = 1.
    - If LOCK_CNT == 1: go to LOCKED, locked = 1.
    - Otherwise: go to VERIFY.
  - No match: stay in HUNT.
- VERIFY:
  - in matches tbl[exp_idx]: phase = exp_idx, exp_idx advances mod 10, match_cnt++.
    - If match_cnt reaches LOCK_CNT: go to LOCKED, locked = 1 on the same edge.
  - Mismatch: go to HUNT, match_cnt = 0. The failing sample is not re-evaluated as a hunt candidate.
- LOCKED:
  - Every valid sample advances: phase = exp_idx, exp_idx advances mod 10 (flywheel), whether the sample matches or not.
  - Match: miss_cnt = 0.
  - Mismatch:
    - err_cnt++ (saturating at 65535, no wrap) and miss_cnt++.
    - If miss_cnt reaches MISS_MAX: go to HUNT, locked = 0, lost = 1 for one cycle, match_cnt = 0, miss_cnt = 0.
- Wrap-around: exp_idx 9 -> 0. The back-to-back zeros (index 9, index 0) are both expected and both match 0.
- err_cnt is cleared only by rst. It holds its value across loss and re-acquisition.

Decomposition:
- Package sin10_pkg holds:
  - SIN10_SIZE = 10;
  - SIN10_TBL[0:9] (the 16-bit signed values above);
  - state encoding HUNT = 0, VERIFY = 1, LOCKED = 2;
  - TOL_MAX = 1945.
  - The generator should share this package.
- One sub-module, sin10_rom: combinational index (4 bits) -> signed 16-bit value. It is used for the expected-value lookup.
- The hunt comparator bank is 8 parallel comparators in the top level.

Test Plan:
- Exact stream from index 0, LOCK_CNT = 4, TOL = 0:
  - Sample 0 keeps HUNT.
  - Sample 21063 -> phase = 1, VERIFY.
  - After sample 11207: locked = 1, phase = 4.
  - Then the pair 0, 0 gives phase 9 then phase 0, err_cnt = 0.
- TOL = 100, locked:
  - in = 32270+100 at expected index 2 -> match.
  - in = 32270+101 -> err_cnt = 1, locked stays 1, phase = 2.
- Locked, MISS_MAX = 3:
  - Inject 2 bad samples, then a good one -> err_cnt = 2, locked = 1, miss_cnt reset.
  - Then 3 consecutive bad samples -> lost = 1 for one cycle, locked = 0, err_cnt = 5.
- VERIFY mismatch:
  - 21063, 32270, then -5000 -> back to HUNT, locked never asserted.
  - Then -11207 -> phase = 5, VERIFY.
- Gaps: toggle in_valid low between samples of an exact stream -> lock sequence identical to the gap-free case, lost stays 0.
- Assert rst asynchronously while locked, mid-cycle -> locked = 0, phase = 0, err_cnt = 0 before the next clk edge; re-acquisition from an arbitrary start index succeeds.

Source files
------------

// File: rtl/sin10_pkg.sv
// Shared definitions for the 10-sample sine LUT generator and its receive-side sync.
package sin10_pkg;

  localparam int SIN10_SIZE = 10;

  // Largest tolerance that keeps every nonzero table entry uniquely matchable.
  localparam int TOL_MAX = 1945;

  localparam logic signed [15:0] SIN10_TBL [0:SIN10_SIZE-1] = '{
    16'sd0,      16'sd21063,  16'sd32270,  16'sd28378,  16'sd11207,
    -16'sd11207, -16'sd28378, -16'sd32270, -16'sd21063, 16'sd0
  };

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sin10_state_e;

  // |a - b| on a 17-bit signed difference; the magnitude always fits in 17 bits.
  function automatic logic [16:0] sin10_abs_diff(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    return d[16] ? 17'(-d) : 17'(d);
  endfunction

  // Table index advance with wrap 9 -> 0.
  function automatic logic [3:0] sin10_next_idx(input logic [3:0] idx);
    return (idx == 4'(SIN10_SIZE - 1)) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/sin10_rom.sv
// Combinational index -> sine sample lookup; out-of-range indices read as zero.
module sin10_rom
  import sin10_pkg::*;
(
  input  logic        [3:0]  idx_i,
  output logic signed [15:0] val_o
);

  // Decode the table index to its sample value.
  always_comb begin
    val_o = '0;
    case (idx_i)
      4'd0: val_o = SIN10_TBL[0];
      4'd1: val_o = SIN10_TBL[1];
      4'd2: val_o = SIN10_TBL[2];
      4'd3: val_o = SIN10_TBL[3];
      4'd4: val_o = SIN10_TBL[4];
      4'd5: val_o = SIN10_TBL[5];
      4'd6: val_o = SIN10_TBL[6];
      4'd7: val_o = SIN10_TBL[7];
      4'd8: val_o = SIN10_TBL[8];
      4'd9: val_o = SIN10_TBL[9];
      default: val_o = '0;
    endcase
  end

endmodule

// File: rtl/sin_lut_10_sync.sv
// Receive-side phase locker for the 10-sample sine stream.
//   state  | meaning
//   HUNT   | searching entries 1..8 for a unique match to seed the phase
//   VERIFY | confirming consecutive expected samples until LOCK_CNT reached
//   LOCKED | flywheel phase tracking, counting mismatches toward loss of lock
module sin_lut_10_sync
  import sin10_pkg::*;
#(
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic signed [15:0] in_i,
  output logic               locked_o,
  output logic        [3:0]  phase_o,
  output logic        [15:0] err_cnt_o,
  output logic               lost_o
);

  // Clamp so a mis-set tolerance can never make two nonzero entries ambiguous.
  localparam int TOL_EFF = (TOL > TOL_MAX) ? TOL_MAX : TOL;

  sin10_state_e state_q, state_d;
  logic [3:0]  exp_idx_q, exp_idx_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        locked_q, locked_d;
  logic        lost_q, lost_d;

  logic signed [15:0] exp_val;
  logic        exp_match;
  logic [3:0]  hunt_hits;
  logic [3:0]  hunt_idx;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;

  sin10_rom u_rom (
    .idx_i (exp_idx_q),
    .val_o (exp_val)
  );

  assign exp_match = (sin10_abs_diff(in_i, exp_val) <= 17'(TOL_EFF));
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  // Hunt comparator bank over the nonzero entries 1..8.
  always_comb begin
    hunt_hits = '0;
    hunt_idx  = '0;
    for (int k = 1; k <= 8; k++) begin
      if (sin10_abs_diff(in_i, SIN10_TBL[k]) <= 17'(TOL_EFF)) begin
        hunt_hits = hunt_hits + 4'd1;
        hunt_idx  = 4'(k);
      end
    end
  end

  // Next-state and output logic; nothing moves without a valid sample.
  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    phase_d     = phase_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    lost_d      = 1'b0;
    if (in_valid_i) begin
      case (state_q)
        HUNT: begin
          if (hunt_hits == 4'd1) begin
            phase_d     = hunt_idx;
            exp_idx_d   = sin10_next_idx(hunt_idx);
            match_cnt_d = 4'd1;
            if (LOCK_CNT == 1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (exp_match) begin
            phase_d     = exp_idx_q;
            exp_idx_d   = sin10_next_idx(exp_idx_q);
            match_cnt_d = match_inc;
            if (match_inc == 4'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            state_d     = HUNT;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          phase_d   = exp_idx_q;
          exp_idx_d = sin10_next_idx(exp_idx_q);
          if (exp_match) begin
            miss_cnt_d = '0;
          end else begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            miss_cnt_d = miss_inc;
            if (miss_inc == 4'(MISS_MAX)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              lost_d      = 1'b1;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end
          end
        end
        default: begin
          state_d     = HUNT;
          locked_d    = 1'b0;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_idx_q   <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      phase_q     <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      phase_q     <= phase_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
    end
  end

  assign locked_o  = locked_q;
  assign phase_o   = phase_q;
  assign err_cnt_o = err_cnt_q;
  assign lost_o    = lost_q;

endmodule
